// File: rtl/piano_pkg.sv
// Shared constants, state encoding and small helpers for the piano-tiles game datapath.
package piano_pkg;

  localparam int unsigned NUM_COLS = 4;

  localparam logic [2:0] LINE_EMPTY = 3'd0;
  localparam logic [2:0] LINE_COL0  = 3'd1;
  localparam logic [2:0] LINE_COL1  = 3'd2;
  localparam logic [2:0] LINE_COL2  = 3'd3;
  localparam logic [2:0] LINE_COL3  = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StJudge,
    StDone
  } check_state_e;

  // Codes 5..7 are not tiles and behave like an empty row.
  function automatic logic line_has_tile(input logic [2:0] line);
    return (line >= LINE_COL0) && (line <= LINE_COL3);
  endfunction

  function automatic logic [1:0] line_col(input logic [2:0] line);
    return 2'(line - LINE_COL0);
  endfunction

  function automatic logic [1:0] lowest_col(input logic [NUM_COLS-1:0] mask);
    logic [1:0] col;
    col = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (mask[i]) col = 2'(i);
    end
    return col;
  endfunction

endpackage

// File: rtl/check_input_if.sv
// Handshake between the game controller, the push-buttons and the input judge.
interface check_input_if;
  import piano_pkg::*;

  logic                check_in_go;
  logic [NUM_COLS-1:0] key_n;
  logic [2:0]          bottom_line;
  logic                check_input_done;
  logic                correct;
  logic                incorrect;
  logic [1:0]          pressed_col;
  logic                timed_out;

  modport master (
    output check_in_go, key_n, bottom_line,
    input  check_input_done, correct, incorrect, pressed_col, timed_out
  );

  modport slave (
    input  check_in_go, key_n, bottom_line,
    output check_input_done, correct, incorrect, pressed_col, timed_out
  );

endinterface

// File: rtl/key_debounce.sv
// Synchronises one active-low push-button and debounces it into a level and a press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            pressed_q, pressed_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            key_level;

  assign key_level = ~sync2_q;

  // Any cycle where the level agrees with the debounced state restarts the count.
  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    pulse_d   = 1'b0;
    if (key_level != pressed_q) begin
      if (cnt_q == CntLast) begin
        pressed_d = key_level;
        pulse_d   = key_level;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed_o     = pressed_q;
  assign press_pulse_o = pulse_q;

endmodule

// File: rtl/check_input.sv
// Judges one player key press (or its absence) against the bottom-row tile per row step.
module check_input
  import piano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input logic         clock,
  input logic         reset,
  check_input_if.slave bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoSat  = TmoW'(TIMEOUT_CYCLES);

  logic [NUM_COLS-1:0] pressed, press_pulse, key_event;

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk_i        (clock),
      .rst_i        (reset),
      .key_n_i      (bus.key_n[i]),
      .pressed_o    (pressed[i]),
      .press_pulse_o(press_pulse[i])
    );
  end

  assign key_event = press_pulse & pressed;

  check_state_e        state_q, state_d;
  logic [2:0]          target_q, target_d;
  logic [TmoW-1:0]     tcnt_q, tcnt_d;
  logic [NUM_COLS-1:0] mask_q, mask_d;
  logic                tmo_q, tmo_d;
  logic                done_q, done_d;
  logic                correct_q, correct_d;
  logic                incorrect_q, incorrect_d;
  logic [1:0]          col_q, col_d;
  logic                timed_out_q, timed_out_d;
  logic                verdict;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    tcnt_d      = tcnt_q;
    mask_d      = mask_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    correct_d   = 1'b0;
    incorrect_d = 1'b0;
    col_d       = '0;
    timed_out_d = 1'b0;
    verdict     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.check_in_go) begin
          target_d = bus.bottom_line;
          tcnt_d   = '0;
          mask_d   = '0;
          tmo_d    = 1'b0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (tcnt_q != TmoSat) tcnt_d = tcnt_q + TmoW'(1);
        // A press arriving in the expiry cycle takes priority over the timeout.
        if (|key_event) begin
          mask_d  = key_event;
          state_d = StJudge;
        end else if (tcnt_q == TmoLast) begin
          tmo_d   = 1'b1;
          state_d = StJudge;
        end
      end
      StJudge: begin
        if (tmo_q) begin
          verdict = !line_has_tile(target_q);
        end else begin
          verdict = line_has_tile(target_q) && $onehot(mask_q) && mask_q[line_col(target_q)];
        end
        done_d      = 1'b1;
        correct_d   = verdict;
        incorrect_d = !verdict;
        col_d       = lowest_col(mask_q);
        timed_out_d = tmo_q;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      target_q    <= LINE_EMPTY;
      tcnt_q      <= '0;
      mask_q      <= '0;
      tmo_q       <= 1'b0;
      done_q      <= 1'b0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      col_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      tcnt_q      <= tcnt_d;
      mask_q      <= mask_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      correct_q   <= correct_d;
      incorrect_q <= incorrect_d;
      col_q       <= col_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.check_input_done = done_q;
  assign bus.correct          = correct_q;
  assign bus.incorrect        = incorrect_q;
  assign bus.pressed_col      = col_q;
  assign bus.timed_out        = timed_out_q;

endmodule

// File: tb/tb_check_input.sv
// Bench for check_input: vector table plus hand sequences, judged by an expectation queue.
module tb_check_input;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 100;
  localparam int PRESS_LAT = 2 + DEB + 2;
  localparam int TMO_LAT   = TMO + 2;

  typedef struct {
    string      name;
    logic [2:0] line;
    logic [3:0] keys;
    int         delay;
    logic       exp_correct;
    logic [1:0] exp_col;
    logic       exp_tmo;
  } vec_t;

  typedef struct {
    string      name;
    logic       correct;
    logic [1:0] col;
    logic       tmo;
    int         due;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  exp_t sb[$];
  vec_t vecs [13];

  check_input_if bus ();

  check_input #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp(input string name, input logic c, input logic [1:0] col,
                          input logic t, input int due);
    exp_t e;
    e.name = name; e.correct = c; e.col = col; e.tmo = t; e.due = due;
    sb.push_back(e);
  endtask

  task automatic do_go(input logic [2:0] line, output int c0);
    c0 = cyc;
    bus.bottom_line = line;
    bus.check_in_go = 1'b1;
    tick(1);
    bus.check_in_go = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  // Output monitor: every done pulse must match the head of the queue, and be quiet otherwise.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.check_input_done) begin
        done_count++;
        chk("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_correct"}, bus.correct, e.correct);
          chk({e.name, "_incorrect"}, bus.incorrect, !e.correct);
          chk({e.name, "_col"}, bus.pressed_col, e.col);
          chk({e.name, "_timed_out"}, bus.timed_out, e.tmo);
          chk({e.name, "_cycle"}, cyc, e.due);
        end
      end else begin
        chk("quiet_outputs", {bus.correct, bus.incorrect, bus.timed_out, bus.pressed_col}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, kstart, due, dc0;

    vecs[0]  = '{"tile1_hit",       3'd2, 4'b0010,  3, 1'b1, 2'd1, 1'b0};
    vecs[1]  = '{"tile2_wrong_col", 3'd3, 4'b0001,  3, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{"tile0_missed",    3'd1, 4'b0000,  0, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{"empty_waited",    3'd0, 4'b0000,  0, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{"two_keys",        3'd1, 4'b0011,  3, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{"empty_pressed",   3'd0, 4'b0100,  3, 1'b0, 2'd2, 1'b0};
    vecs[6]  = '{"tile3_hit",       3'd4, 4'b1000,  3, 1'b1, 2'd3, 1'b0};
    vecs[7]  = '{"code7_waited",    3'd7, 4'b0000,  0, 1'b1, 2'd0, 1'b1};
    vecs[8]  = '{"code5_pressed",   3'd5, 4'b0001,  3, 1'b0, 2'd0, 1'b0};
    vecs[9]  = '{"two_keys_hi",     3'd3, 4'b1100,  3, 1'b0, 2'd2, 1'b0};
    vecs[10] = '{"press_at_expiry", 3'd2, 4'b0010, 93, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{"press_too_late",  3'd2, 4'b0010, 94, 1'b0, 2'd0, 1'b1};
    vecs[12] = '{"tile0_hit_early", 3'd1, 4'b0001,  1, 1'b1, 2'd0, 1'b0};

    reset = 1'b1;
    bus.check_in_go = 1'b0;
    bus.key_n = 4'hF;
    bus.bottom_line = 3'd0;
    tick(3);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_done", bus.check_input_done, 0);
    chk("reset_correct", bus.correct, 0);
    chk("reset_incorrect", bus.incorrect, 0);
    tick(2);

    foreach (vecs[v]) begin
      do_go(vecs[v].line, c0);
      if (vecs[v].keys != 4'b0000) begin
        tick(vecs[v].delay);
        kstart = cyc;
        due = vecs[v].exp_tmo ? c0 + TMO_LAT : kstart + PRESS_LAT;
        push_exp(vecs[v].name, vecs[v].exp_correct, vecs[v].exp_col, vecs[v].exp_tmo, due);
        bus.key_n = ~vecs[v].keys;
        tick(10);
        bus.key_n = 4'hF;
      end else begin
        push_exp(vecs[v].name, vecs[v].exp_correct, vecs[v].exp_col, vecs[v].exp_tmo,
                 c0 + TMO_LAT);
      end
      drain(vecs[v].name, 3 * TMO);
      tick(10);
    end

    // Key held across go produces no event; a fresh press in the next check does.
    bus.key_n[3] = 1'b0;
    tick(10);
    do_go(3'd4, c0);
    push_exp("held_key", 1'b0, 2'd0, 1'b1, c0 + TMO_LAT);
    drain("held_key", 3 * TMO);
    bus.key_n[3] = 1'b1;
    tick(10);
    do_go(3'd4, c0);
    tick(3);
    kstart = cyc;
    push_exp("repress", 1'b1, 2'd3, 1'b0, kstart + PRESS_LAT);
    bus.key_n[3] = 1'b0;
    tick(10);
    bus.key_n[3] = 1'b1;
    drain("repress", 3 * TMO);
    tick(10);

    // Bouncing key never settles, so the tile is missed by timeout.
    do_go(3'd3, c0);
    push_exp("bounce", 1'b0, 2'd0, 1'b1, c0 + TMO_LAT);
    for (int i = 0; i < 5; i++) begin
      bus.key_n[2] = 1'b0;
      tick(2);
      bus.key_n[2] = 1'b1;
      tick(2);
    end
    drain("bounce", 3 * TMO);
    tick(10);

    // Reset mid-check aborts it without a done pulse.
    dc0 = done_count;
    do_go(3'd2, c0);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus.key_n[1] = 1'b0;
    tick(10);
    bus.key_n[1] = 1'b1;
    tick(20);
    chk("reset_abort_dones", done_count - dc0, 0);

    // A second go while waiting is neither latched nor queued.
    dc0 = done_count;
    do_go(3'd1, c0);
    tick(5);
    bus.bottom_line = 3'd0;
    bus.check_in_go = 1'b1;
    tick(1);
    bus.check_in_go = 1'b0;
    tick(2);
    kstart = cyc;
    push_exp("go_in_wait", 1'b1, 2'd0, 1'b0, kstart + PRESS_LAT);
    bus.key_n[0] = 1'b0;
    tick(10);
    bus.key_n[0] = 1'b1;
    drain("go_in_wait", 3 * TMO);
    tick(TMO + 20);
    chk("one_done_per_go", done_count - dc0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
